// File: rtl/frv_gprs_pkg.sv
// Shared types and sizes for the GPR write-port controller and its arbiter.
package frv_gprs_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int XLEN         = 32;
    localparam int NUM_GPRS     = 32;
    localparam int SWEEP_WRITES = NUM_GPRS / 2;
    localparam int SWEEP_IDX_W  = $clog2(SWEEP_WRITES + 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } wport_state_e;

    typedef struct packed {
        logic                  wide;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       wdata;
        logic [XLEN-1:0]       wdata_hi;
    } wr_req_t;

endpackage

// File: rtl/frv_gprs_wport_arb.sv
// Two-requester write-port arbiter: A has priority unless B has waited
// STARVE_LIMIT consecutive cycles, in which case B wins one grant.
module frv_gprs_wport_arb
    import frv_gprs_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic run,
    input  logic a_valid,
    input  logic b_valid,
    output logic grant_a,
    output logic grant_b
);

    localparam logic [3:0] STARVE_MAX = 4'd15;
    localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    // NOTE: combinational outputs get a value on every path so no latch is inferred.
    always_comb begin
        grant_b = run && b_valid && (!a_valid || (r_starve_cnt >= LIMIT));
        grant_a = run && a_valid && !grant_b;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_starve_cnt <= '0;
        end else if (!run || !b_valid || grant_b) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/frv_gprs_wport_ctrl.sv
// Register-file write-port owner: optional post-reset zeroing sweep, then
// arbitrated writeback from the main pipeline (A) and long-latency unit (B).
module frv_gprs_wport_ctrl
    import frv_gprs_pkg::*;
#(
    parameter bit INIT_ZERO    = 1'b1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_wide,
    input  logic [REG_ADDR_W-1:0] a_addr,
    input  logic [XLEN-1:0]       a_wdata,
    input  logic [XLEN-1:0]       a_wdata_hi,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_wide,
    input  logic [REG_ADDR_W-1:0] b_addr,
    input  logic [XLEN-1:0]       b_wdata,
    input  logic [XLEN-1:0]       b_wdata_hi,
    output logic                  rd_wen,
    output logic                  rd_wide,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_wdata,
    output logic [XLEN-1:0]       rd_wdata_hi,
    output logic                  init_done,
    output logic                  wr_err
);

    localparam wport_state_e             RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;
    localparam logic [SWEEP_IDX_W-1:0]   SWEEP_END   = SWEEP_IDX_W'(SWEEP_WRITES);

    wport_state_e           r_state;
    wport_state_e           w_state_nxt;
    logic [SWEEP_IDX_W-1:0] r_sweep_idx;
    logic                   w_sweep_wr;
    logic                   w_grant_a;
    logic                   w_grant_b;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_illegal;
    wr_req_t                w_req;

    frv_gprs_wport_arb #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .run      (init_done),
        .a_valid  (a_valid),
        .b_valid  (b_valid),
        .grant_a  (w_grant_a),
        .grant_b  (w_grant_b)
    );

    assign a_ready = w_grant_a;
    assign b_ready = w_grant_b;

    // Sweep idles one cycle at index 16 so RUN starts after the last write is visible.
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_wr  = 1'b0;
        if (r_state == ST_INIT) begin
            if (r_sweep_idx != SWEEP_END) begin
                w_sweep_wr = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_comb begin
        w_req     = w_grant_b ? {b_wide, b_addr, b_wdata, b_wdata_hi}
                              : {a_wide, a_addr, a_wdata, a_wdata_hi};
        w_accept  = w_grant_a || w_grant_b;
        w_illegal = w_accept && w_req.wide && w_req.addr[0];
        w_legal   = w_accept && (w_req.wide ? !w_req.addr[0] : (w_req.addr != '0));
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            r_state     <= RESET_STATE;
            r_sweep_idx <= '0;
            init_done   <= 1'b0;
            wr_err      <= 1'b0;
            rd_wen      <= 1'b0;
            rd_wide     <= 1'b0;
            rd_addr     <= '0;
            rd_wdata    <= '0;
            rd_wdata_hi <= '0;
        end else begin
            r_state   <= w_state_nxt;
            init_done <= (w_state_nxt == ST_RUN);
            wr_err    <= w_illegal;
            rd_wen    <= w_sweep_wr || w_legal;
            if (w_sweep_wr) begin
                r_sweep_idx <= r_sweep_idx + 1'b1;
                rd_wide     <= 1'b1;
                rd_addr     <= {r_sweep_idx[SWEEP_IDX_W-2:0], 1'b0};
                rd_wdata    <= '0;
                rd_wdata_hi <= '0;
            end else if (w_legal) begin
                rd_wide     <= w_req.wide;
                rd_addr     <= w_req.addr;
                rd_wdata    <= w_req.wdata;
                rd_wdata_hi <= w_req.wdata_hi;
            end
        end
    end

endmodule
